uart_word_tx: RTL and testbench

Parametrised UART transmitter that serialises one wide word, such as a 160-bit digest, as a sequence of UART characters. It has an internal baud-rate divider, configurable character width, optional parity and 1 or 2 stop bits. It succeeds the fixed 160-bit tx path with its external baud enable. It sits between a hash or context producer and the serial line, and pairs with the team's receiver for loopback checks.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_baud_cnt.sv | 29 ++
 rtl/uart_word_tx.sv | 138 +++++++++++++
 tb/tb_uart_word_tx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and elaboration-time helpers for the word-level UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} uart_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned pow;
    res = 0;
    pow = 1;
    while (pow < value) begin
      pow = pow << 1;
      res++;
    end
    return res;
  endfunction

  function automatic int unsigned num_chars(input int unsigned word_w,
                                            input int unsigned data_bits);
    return (word_w + data_bits - 1) / data_bits;
  endfunction

  function automatic int unsigned frame_len(input int unsigned data_bits,
                                            input int unsigned parity_en,
                                            input int unsigned stop_bits,
                                            input int unsigned clks_per_bit);
    return (1 + data_bits + parity_en + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: bit_tick marks the last clk cycle of each bit period.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_tick
);

  localparam int unsigned CntW = (clog2(CLKS_PER_BIT) > 0) ? clog2(CLKS_PER_BIT) : 1;

  logic [CntW-1:0] cnt_q;

  assign bit_tick = (cnt_q == CntW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || bit_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_word_tx.sv
// Serialises one wide word as a sequence of UART characters, most-significant character first.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int unsigned WORD_W       = 160,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        wr_en,
  input  logic [WORD_W-1:0]                           tx_data,
  output logic                                        tx_out,
  output logic                                        tx_busy,
  output logic                                        tx_done,
  output logic [clog2(num_chars(WORD_W, DATA_BITS)):0] char_idx
);

  localparam int unsigned NumChars = num_chars(WORD_W, DATA_BITS);
  localparam int unsigned TotalW   = NumChars * DATA_BITS;
  localparam int unsigned PadW     = TotalW - WORD_W;
  localparam int unsigned CidxW    = clog2(NumChars) + 1;

  uart_state_e          state_q;
  logic [TotalW-1:0]    sr_q;
  logic [TotalW-1:0]    padded;
  logic [TotalW-1:0]    load_src;
  logic [TotalW-1:0]    next_sr;
  logic [DATA_BITS-1:0] chr_q;
  logic [DATA_BITS-1:0] next_chr;
  logic                 next_par;
  logic                 par_q;
  logic [3:0]           bit_idx_q;
  logic                 stop_idx_q;
  logic                 bit_tick;

  // Left-align the word; padding zeros sit at the LSB end of the last character.
  assign padded   = TotalW'(tx_data) << PadW;
  assign load_src = (state_q == StIdle) ? padded : sr_q;
  assign next_chr = load_src[TotalW-1 -: DATA_BITS];
  assign next_sr  = load_src << DATA_BITS;
  assign next_par = (^next_chr) ^ 1'(PARITY_ODD);

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state_q == StIdle),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      tx_out     <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      char_idx   <= '0;
      sr_q       <= '0;
      chr_q      <= '0;
      par_q      <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (wr_en) begin
            state_q  <= StStart;
            tx_out   <= 1'b0;
            tx_busy  <= 1'b1;
            char_idx <= '0;
            sr_q     <= next_sr;
            chr_q    <= next_chr;
            par_q    <= next_par;
          end
        end
        StStart: begin
          if (bit_tick) begin
            state_q   <= StData;
            tx_out    <= chr_q[0];
            chr_q     <= chr_q >> 1;
            bit_idx_q <= '0;
          end
        end
        StData: begin
          if (bit_tick) begin
            if (bit_idx_q == 4'(DATA_BITS - 1)) begin
              if (PARITY_EN != 0) begin
                state_q <= StParity;
                tx_out  <= par_q;
              end else begin
                state_q    <= StStop;
                tx_out     <= 1'b1;
                stop_idx_q <= 1'b0;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              tx_out    <= chr_q[0];
              chr_q     <= chr_q >> 1;
            end
          end
        end
        StParity: begin
          if (bit_tick) begin
            state_q    <= StStop;
            tx_out     <= 1'b1;
            stop_idx_q <= 1'b0;
          end
        end
        StStop: begin
          if (bit_tick) begin
            if (stop_idx_q != 1'(STOP_BITS - 1)) begin
              stop_idx_q <= 1'b1;
            end else if (char_idx == CidxW'(NumChars - 1)) begin
              state_q <= StIdle;
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
            end else begin
              state_q  <= StStart;
              tx_out   <= 1'b0;
              char_idx <= char_idx + 1'b1;
              sr_q     <= next_sr;
              chr_q    <= next_chr;
              par_q    <= next_par;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx across five parameter sets, with a bench-side UART receiver.
module tb_uart_word_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [159:0] dat;
  logic         wr  [5];
  logic         txo [5];
  logic         bsy [5];
  logic         dn  [5];
  logic [5:0]   ci0;
  logic [1:0]   ci1, ci2, ci3;
  logic [0:0]   ci4;
  int           done_cnt [5] = '{default: 0};
  int           n_checks = 0;
  int           n_fails  = 0;

  uart_word_tx u0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr[0]), .tx_data(dat),
    .tx_out(txo[0]), .tx_busy(bsy[0]), .tx_done(dn[0]), .char_idx(ci0)
  );
  uart_word_tx #(.WORD_W(16), .CLKS_PER_BIT(4)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr[1]), .tx_data(dat[15:0]),
    .tx_out(txo[1]), .tx_busy(bsy[1]), .tx_done(dn[1]), .char_idx(ci1)
  );
  uart_word_tx #(.WORD_W(12), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr[2]), .tx_data(dat[11:0]),
    .tx_out(txo[2]), .tx_busy(bsy[2]), .tx_done(dn[2]), .char_idx(ci2)
  );
  uart_word_tx #(.WORD_W(12), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u3 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr[3]), .tx_data(dat[11:0]),
    .tx_out(txo[3]), .tx_busy(bsy[3]), .tx_done(dn[3]), .char_idx(ci3)
  );
  uart_word_tx #(.WORD_W(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) u4 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr[4]), .tx_data(dat[7:0]),
    .tx_out(txo[4]), .tx_busy(bsy[4]), .tx_done(dn[4]), .char_idx(ci4)
  );

  always @(posedge clk) begin
    for (int k = 0; k < 5; k++) begin
      if (dn[k] === 1'b1) done_cnt[k] <= done_cnt[k] + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int inst, input logic [159:0] word);
    @(negedge clk);
    dat       = word;
    wr[inst]  = 1'b1;
    @(posedge clk);
    #1 wr[inst] = 1'b0;
  endtask

  // Called just after the acceptance edge; cycle j is the j-th cycle after it.
  // A nonzero poke raises wr_en with another word at that cycle and leaves it high.
  task automatic check_stream(input int inst, input logic [0:63] bits, input int nbits,
                              input int cpb, input int poke, input string tag);
    int bad = 0;
    int early_done = 0;
    for (int j = 1; j <= nbits * cpb; j++) begin
      @(negedge clk);
      if (j == poke) begin
        dat      = 160'h1234;
        wr[inst] = 1'b1;
      end
      if (j == 1) check_val({tag, "_busy"}, 32'(bsy[inst]), 32'd1);
      if (txo[inst] !== bits[(j-1)/cpb]) bad++;
      if (dn[inst] !== 1'b0) early_done++;
    end
    check_val({tag, "_line_bad_cycles"}, 32'(bad), 32'd0);
    check_val({tag, "_early_done"}, 32'(early_done), 32'd0);
    @(negedge clk);
    check_val({tag, "_done"}, 32'(dn[inst]), 32'd1);
    check_val({tag, "_idle_line"}, 32'(txo[inst]), 32'd1);
    check_val({tag, "_busy_low"}, 32'(bsy[inst]), 32'd0);
  endtask

  logic [0:63] s_basic, s_peven, s_podd, s_stop, s_b2b;
  logic [7:0]  exp_bytes [20];
  logic [7:0]  rx;
  int          bad, base, wait_n;

  initial begin
    s_basic = {20'b0_10100101_1_0_11000011_1, 44'b0};
    s_peven = {22'b0_11111111_0_1_0_00001111_0_1, 42'b0};
    s_podd  = {22'b0_11111111_1_1_0_00001111_1_1, 42'b0};
    s_stop  = {11'b0_00000000_1_1, 53'b0};
    s_b2b   = {20'b0_01001000_1_0_00101100_1, 44'b0};
    exp_bytes = '{8'h67, 8'h45, 8'h23, 8'h01, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h98, 8'hBA,
                  8'hDC, 8'hFE, 8'h10, 8'h32, 8'h54, 8'h76, 8'hC3, 8'hD2, 8'hE1, 8'hF0};

    rst_n = 1'b0;
    dat   = '0;
    for (int k = 0; k < 5; k++) wr[k] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check_val($sformatf("reset_line%0d", k), 32'(txo[k]), 32'd1);
      check_val($sformatf("reset_busy%0d", k), 32'(bsy[k]), 32'd0);
    end
    check_val("reset_cidx", 32'(ci0), 32'd0);
    rst_n = 1'b1;

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      for (int k = 0; k < 5; k++) if (txo[k] !== 1'b1 || bsy[k] !== 1'b0) bad++;
    end
    check_val("idle_bad_cycles", 32'(bad), 32'd0);
    check_val("idle_done_pulses",
              32'(done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3] + done_cnt[4]), 32'd0);

    send(1, 160'hA5C3);
    check_stream(1, s_basic, 20, 4, 0, "basic");
    check_val("basic_last_cidx", 32'(ci1), 32'd1);

    send(2, 160'hFFF);
    check_stream(2, s_peven, 22, 4, 0, "par_even");
    send(3, 160'hFFF);
    check_stream(3, s_podd, 22, 4, 0, "par_odd");

    send(4, 160'h00);
    check_stream(4, s_stop, 11, 4, 0, "stop2");

    // Mid-transfer request ignored; held request picked up after tx_done.
    send(1, 160'hA5C3);
    check_stream(1, s_basic, 20, 4, 20, "busy_ignore");
    @(posedge clk);
    #1 wr[1] = 1'b0;
    check_stream(1, s_b2b, 20, 4, 0, "b2b");

    send(1, 160'hA5C3);
    repeat (50) @(negedge clk);
    check_val("rst_mid_cidx", 32'(ci1), 32'd1);
    base = done_cnt[1];
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_async_line", 32'(txo[1]), 32'd1);
    check_val("rst_async_busy", 32'(bsy[1]), 32'd0);
    check_val("rst_async_done", 32'(dn[1]), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (txo[1] !== 1'b1 || bsy[1] !== 1'b0) bad++;
    end
    check_val("rst_after_bad_cycles", 32'(bad), 32'd0);
    check_val("rst_no_done", 32'(done_cnt[1] - base), 32'd0);
    check_val("rst_cidx", 32'(ci1), 32'd0);

    send(0, 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0);
    for (int c = 0; c < 20; c++) begin
      wait_n = 0;
      do begin
        @(negedge clk);
        wait_n++;
      end while (txo[0] !== 1'b0 && wait_n < 400);
      check_val($sformatf("rx_start_found%0d", c), 32'(txo[0]), 32'd0);
      if (txo[0] !== 1'b0) break;
      repeat (8) @(negedge clk);
      for (int b = 0; b < 8; b++) begin
        repeat (16) @(negedge clk);
        rx[b] = txo[0];
      end
      repeat (16) @(negedge clk);
      check_val($sformatf("rx_stop%0d", c), 32'(txo[0]), 32'd1);
      check_val($sformatf("rx_byte%0d", c), 32'(rx), 32'(exp_bytes[c]));
    end
    wait_n = 0;
    while (dn[0] !== 1'b1 && wait_n < 40) begin
      @(negedge clk);
      wait_n++;
    end
    check_val("rx_word_done", 32'(dn[0]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
